im_loader: RTL and testbench

Instruction-memory loader: the write side of the 256-byte instruction memory. It accepts a byte stream over a valid/ready handshake and writes the bytes into consecutive byte addresses starting at 0, in the same big-endian order the fetch side reads. The first byte received becomes bits [31:24] of the instruction at address 0. It holds the CPU in reset until a load completes, then releases it.

---
 rtl/im_loader.sv | 70 +++++++
 tb/tb_im_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: writes a byte stream into consecutive instruction-memory addresses
// and holds the CPU in reset until the load completes.
module im_loader #(
   parameter int DEPTH = 256,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   load_len,
   input  logic [7:0]    byte_in,
   input  logic          byte_valid,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          cpu_hold,
   output logic [7:0]    checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   state_t state;
   logic [AW:0] len, count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         len <= '0;
         count <= '0;
         byte_ready <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         cpu_hold <= 1'b1;
         checksum <= '0;
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            IDLE, DONE: if (start && load_len != '0) begin
               state <= LOAD;
               len <= (load_len > FULL) ? FULL : load_len;
               count <= '0;
               checksum <= '0;
               byte_ready <= 1'b1;
               busy <= 1'b1;
               done <= 1'b0;
               cpu_hold <= 1'b1;
            end
            LOAD: if (byte_valid && byte_ready) begin
               mem_we <= 1'b1;
               mem_addr <= count[AW-1:0];
               mem_wdata <= byte_in;
               count <= count + 1'b1;
               checksum <= checksum + byte_in;
               if (count == len - 1'b1) begin
                  state <= DONE;
                  byte_ready <= 1'b0;
                  busy <= 1'b0;
                  done <= 1'b1;
                  cpu_hold <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: table-driven loads checked against a write scoreboard,
// plus hand-written reset, ignored-request and mid-load reset sequences.
module tb_im_loader;
   logic clk = 0, rst_n = 0, start = 0, byte_valid = 0;
   logic [8:0] load_len = 0;
   logic [7:0] byte_in = 0;
   logic byte_ready, mem_we, busy, done, cpu_hold;
   logic [7:0] mem_addr, mem_wdata, checksum;

   im_loader #(.DEPTH(256), .AW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] len;
      int send;
      bit inc;
      bit stall;
      bit poke;
      logic [7:0] csum;
      int writes;
   } vec_t;
   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   vec_t tbl[4];
   wr_t q[$];
   logic [7:0] mem [256];
   logic [7:0] lst [4];
   int gaps [3];
   int ncmp = 0, nerr = 0, nwr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // every observed write must match the oldest accepted byte
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n && mem_we) begin
         nwr++;
         mem[mem_addr] = mem_wdata;
         if (q.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
         end else begin
            e = q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.a));
            chk("wr_data", 32'(mem_wdata), 32'(e.d));
         end
      end
   end

   task automatic chk_reset();
      chk("rst_byte_ready", 32'(byte_ready), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cpu_hold", 32'(cpu_hold), 1);
      chk("rst_checksum", 32'(checksum), 0);
   endtask

   task automatic run_load(input vec_t v);
      int w0;
      w0 = nwr;
      start = 1; load_len = v.len;
      @(posedge clk); #1;
      start = 0; load_len = 0;
      chk("start_busy", 32'(busy), 1);
      chk("start_ready", 32'(byte_ready), 1);
      chk("start_done", 32'(done), 0);
      chk("start_hold", 32'(cpu_hold), 1);
      chk("start_csum", 32'(checksum), 0);
      for (int i = 0; i < v.send; i++) begin
         if (v.stall) repeat (gaps[i % 3]) begin
            byte_valid = 0;
            @(posedge clk); #1;
            chk("gap_busy", 32'(busy), 1);
         end
         byte_valid = 1;
         byte_in = v.inc ? 8'(i) : lst[i % 4];
         if (v.poke && i == 1) begin start = 1; load_len = 9'd1; end
         if (byte_ready) q.push_back('{8'(i), byte_in});
         @(posedge clk); #1;
         start = 0; load_len = 0;
      end
      byte_valid = 0;
      @(negedge clk); #1;
      chk("end_done", 32'(done), 1);
      chk("end_busy", 32'(busy), 0);
      chk("end_ready", 32'(byte_ready), 0);
      chk("end_hold", 32'(cpu_hold), 0);
      chk("end_csum", 32'(checksum), 32'(v.csum));
      chk("end_writes", 32'(nwr - w0), 32'(v.writes));
      chk("end_pending", 32'(q.size()), 0);
   endtask

   initial begin
      lst = '{8'h20, 8'h08, 8'h00, 8'h05};
      gaps = '{0, 2, 5};
      tbl[0] = '{9'd4,   4,   1'b0, 1'b0, 1'b0, 8'h2D, 4};
      tbl[1] = '{9'd3,   3,   1'b1, 1'b1, 1'b1, 8'h03, 3};
      tbl[2] = '{9'd256, 256, 1'b1, 1'b0, 1'b0, 8'h80, 256};
      tbl[3] = '{9'd300, 257, 1'b1, 1'b0, 1'b0, 8'h80, 256};

      repeat (4) begin
         @(posedge clk); #1;
         start = 1'($urandom); byte_valid = 1'($urandom);
         load_len = 9'($urandom); byte_in = 8'($urandom);
      end
      @(negedge clk);
      chk_reset();
      start = 0; byte_valid = 0; load_len = 0; byte_in = 0;
      @(posedge clk); #1 rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_hold", 32'(cpu_hold), 1);
      chk("idle_ready", 32'(byte_ready), 0);

      start = 1; load_len = 0;
      @(posedge clk); #1 start = 0;
      chk("len0_busy", 32'(busy), 0);
      chk("len0_ready", 32'(byte_ready), 0);
      chk("len0_hold", 32'(cpu_hold), 1);

      for (int k = 0; k < 4; k++) begin
         run_load(tbl[k]);
         if (k == 0) chk("word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h20080005);
      end

      start = 1; load_len = 0;
      @(posedge clk); #1 start = 0;
      chk("done_len0_done", 32'(done), 1);
      chk("done_len0_busy", 32'(busy), 0);

      run_load('{9'd2, 2, 1'b1, 1'b0, 1'b0, 8'h01, 2});

      start = 1; load_len = 9'd8;
      @(posedge clk); #1 start = 0; load_len = 0;
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1; byte_in = 8'(8'h40 + i);
         q.push_back('{8'(i), byte_in});
         @(posedge clk); #1;
      end
      byte_valid = 0;
      @(negedge clk); #1;
      chk("mid_pending", 32'(q.size()), 0);
      rst_n = 0;
      #1 chk_reset();
      @(posedge clk); #1 rst_n = 1;
      run_load('{9'd2, 2, 1'b1, 1'b0, 1'b0, 8'h01, 2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
